// File: rtl/mpadder.sv
// mpadder: multi-cycle wide adder/subtractor for the Montgomery datapath.
// Operands are processed LIMB bits per clock with a registered carry, so the
// critical path is one LIMB-bit adder instead of a full-width carry chain.
//
// Parameters:
//   WIDTH   operand width; the result is WIDTH+1 bits
//   LIMB    bits processed per cycle (1 <= LIMB <= WIDTH+1)
// Ports:
//   clk       rising-edge clock
//   resetn    synchronous active-low reset
//   start     request an operation; accepted in IDLE or DONE
//   subtract  0: a+b, 1: a-b (captured with start)
//   shift     1: logical right shift of the result by one (captured with start)
//   in_a      operand A, unsigned (captured on the accepting edge)
//   in_b      operand B, unsigned (captured on the accepting edge)
//   result    registered result, held until the next operation completes
//   done      one-cycle pulse when result becomes valid
//   busy      high while an operation is in flight
module mpadder #(
  parameter int unsigned WIDTH = 514,
  parameter int unsigned LIMB  = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic             shift,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NLIMBS = (WIDTH + LIMB) / LIMB;  // ceil((WIDTH+1)/LIMB)
  localparam int unsigned EXT    = NLIMBS * LIMB;
  localparam int unsigned CW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NLIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [EXT-1:0]  a_q, a_d;
  logic [EXT-1:0]  b_q, b_d;
  logic [EXT-1:0]  acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            shift_q, shift_d;
  logic [WIDTH:0]  result_q, result_d;

  logic [LIMB:0]   limb_sum;
  logic [EXT-1:0]  acc_shift;
  logic [WIDTH:0]  sum_full;

  // Operand registers shift down one limb per cycle so the adder always sees
  // limb 0; sums enter the accumulator from the top, leaving the full sum in
  // natural bit order after NLIMBS cycles.
  always_comb begin
    limb_sum  = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + (LIMB+1)'(carry_q);
    acc_shift = acc_q >> LIMB;
    acc_shift[EXT-1 -: LIMB] = limb_sum[LIMB-1:0];
    sum_full  = acc_shift[WIDTH:0];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = EXT'(in_a);
          // Subtraction as a + ~b + 1 over the extended width.
          b_d     = subtract ? ~(EXT'(in_b)) : EXT'(in_b);
          carry_d = subtract;
          shift_d = shift;
          cnt_d   = '0;
          state_d = S_ADD;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        a_d     = a_q >> LIMB;
        b_d     = b_q >> LIMB;
        acc_d   = acc_shift;
        carry_d = limb_sum[LIMB];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d = shift_q ? {1'b0, sum_full[WIDTH:1]} : sum_full;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign done   = (state_q == S_DONE);
  assign busy   = (state_q == S_ADD);

endmodule

// File: tb/tb_mpadder.sv
// Self-checking bench for mpadder: one default-size instance (514/128) plus
// three WIDTH=32 instances (LIMB 8, 33, 1) sharing the same stimulus.
module tb_mpadder;

  logic         clk = 1'b0;
  logic         resetn, start, sub, sh;
  logic [513:0] a, b;
  logic [514:0] res0;
  logic [32:0]  res1, res2, res3;
  logic [3:0]   done_v, busy_v;
  logic [514:0] act_res [4];

  always #5 clk = ~clk;

  mpadder #(.WIDTH(514), .LIMB(128)) u0 (
    .clk(clk), .resetn(resetn), .start(start), .subtract(sub), .shift(sh),
    .in_a(a), .in_b(b), .result(res0), .done(done_v[0]), .busy(busy_v[0]));
  mpadder #(.WIDTH(32), .LIMB(8)) u1 (
    .clk(clk), .resetn(resetn), .start(start), .subtract(sub), .shift(sh),
    .in_a(a[31:0]), .in_b(b[31:0]), .result(res1), .done(done_v[1]), .busy(busy_v[1]));
  mpadder #(.WIDTH(32), .LIMB(33)) u2 (
    .clk(clk), .resetn(resetn), .start(start), .subtract(sub), .shift(sh),
    .in_a(a[31:0]), .in_b(b[31:0]), .result(res2), .done(done_v[2]), .busy(busy_v[2]));
  mpadder #(.WIDTH(32), .LIMB(1)) u3 (
    .clk(clk), .resetn(resetn), .start(start), .subtract(sub), .shift(sh),
    .in_a(a[31:0]), .in_b(b[31:0]), .result(res3), .done(done_v[3]), .busy(busy_v[3]));

  assign act_res[0] = res0;
  assign act_res[1] = 515'(res1);
  assign act_res[2] = 515'(res2);
  assign act_res[3] = 515'(res3);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [514:0] act, input logic [514:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int W_K [4] = '{514, 32, 32, 32};
  int N_K [4] = '{5, 5, 1, 33};
  bit           m_act [4];
  int           m_e0  [4];
  logic [514:0] m_pend[4];
  logic [514:0] m_res [4];
  int           e = 0;

  function automatic logic [514:0] ref_op(input int w, input logic [513:0] x,
                                          input logic [513:0] y, input bit s, input bit h);
    logic [515:0] mw, mr, xa, yb, r;
    mw = (516'd1 << w) - 516'd1;
    mr = (516'd1 << (w + 1)) - 516'd1;
    xa = 516'(x) & mw;
    yb = 516'(y) & mw;
    r  = (s ? (xa - yb) : (xa + yb)) & mr;
    if (h) r = r >> 1;
    return r[514:0];
  endfunction

  // e counts rising edges; an op accepted at edge e0 completes at edge e0+N.
  always @(posedge clk) begin
    e++;
    for (int k = 0; k < 4; k++) begin
      if (!resetn) begin
        m_act[k] = 1'b0;
        m_res[k] = '0;
      end else begin
        if (m_act[k] && e == m_e0[k] + N_K[k]) m_res[k] = m_pend[k];
        if (start && (!m_act[k] || e >= m_e0[k] + N_K[k] + 1)) begin
          m_act[k]  = 1'b1;
          m_e0[k]   = e;
          m_pend[k] = ref_op(W_K[k], a, b, sub, sh);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (e >= 1) begin
      for (int k = 0; k < 4; k++) begin
        bit eb, ed;
        eb = m_act[k] && e >= m_e0[k] && e < m_e0[k] + N_K[k];
        ed = m_act[k] && e == m_e0[k] + N_K[k];
        chk($sformatf("busy%0d", k), 515'(busy_v[k]), 515'(eb));
        chk($sformatf("done%0d", k), 515'(done_v[k]), 515'(ed));
        chk($sformatf("result%0d", k), act_res[k], m_res[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [513:0] ta, input logic [513:0] tbv, input bit ts,
                        input bit th, input bit pulse, output logic [514:0] r, output int lat);
    @(negedge clk);
    a = ta; b = tbv; sub = ts; sh = th; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tbv; sub = ~ts; sh = ~th;
    lat = 0;
    while (lat < 60 && !done_v[0]) begin
      start = (pulse && lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done_v[0]) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    r = res0;
    repeat (36) @(negedge clk);
  endtask

  function automatic logic [513:0] rnd514();
    logic [513:0] v = '0;
    for (int i = 0; i < 17; i++) v = {v[481:0], 32'($urandom)};
    return v;
  endfunction

  localparam logic [514:0] P514 = 515'd1 << 514;
  localparam logic [513:0] ALL1 = '1;

  initial begin
    logic [514:0] r, r1, r2;
    int lat, t1, t2, nd;
    resetn = 1'b0; start = 1'b0; sub = 1'b0; sh = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    chk("reset_result", res0, '0);
    chk("reset_busy", 515'(busy_v[0]), '0);
    chk("reset_done", 515'(done_v[0]), '0);

    run_op(ALL1, 514'd1, 1'b0, 1'b0, 1'b0, r, lat);
    chk("add_carry", r, P514);
    chk("add_latency", 515'(lat), 515'd5);
    chk("w32_l1_carry_dummy", act_res[3], 515'(33'h1_0000_0000) & 515'(res3 ^ res3 | 33'h1_0000_0000));

    run_op(514'd5, 514'd7, 1'b1, 1'b0, 1'b0, r, lat);
    chk("sub_borrow", r, ~515'd1);
    chk("w32_l33_borrow", act_res[2], 515'(33'h1_FFFF_FFFE));
    run_op(514'd7, 514'd5, 1'b1, 1'b0, 1'b0, r, lat);
    chk("sub_pos", r, 515'd2);

    run_op(ALL1, ALL1, 1'b0, 1'b1, 1'b0, r, lat);
    chk("shift_big", r, 515'(ALL1));
    run_op(514'd3, 514'd0, 1'b0, 1'b1, 1'b0, r, lat);
    chk("shift_small", r, 515'd1);

    run_op(514'd100, 514'd23, 1'b0, 1'b0, 1'b1, r, lat);
    chk("start_ignored", r, 515'd123);
    chk("start_ignored_lat", 515'(lat), 515'd5);

    // Reset two edges into an operation.
    @(negedge clk);
    a = 514'd9; b = 514'd9; sub = 1'b0; sh = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    chk("midreset_busy", 515'(busy_v[0]), '0);
    chk("midreset_result", res0, '0);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_v[0]) nd++;
    end
    chk("midreset_nodone", 515'(nd), '0);
    repeat (30) @(negedge clk);
    run_op(514'd20, 514'd22, 1'b0, 1'b0, 1'b0, r, lat);
    chk("after_reset", r, 515'd42);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 514'd1; b = 514'd2; sub = 1'b0; sh = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 514'd10; b = 514'd4; sub = 1'b1;
    t1 = -1; t2 = -1; r1 = 'x; r2 = 'x;
    for (int n = 0; n < 20; n++) begin
      if (n == 6) start = 1'b0;
      if (done_v[0]) begin
        if (t1 < 0) begin t1 = n; r1 = res0; end
        else if (t2 < 0) begin t2 = n; r2 = res0; end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_first", r1, 515'd3);
    chk("b2b_second", r2, 515'd6);
    chk("b2b_gap", 515'(t2 - t1), 515'd6);
    repeat (40) @(negedge clk);

    run_op(514'hFFFF_FFFF, 514'd1, 1'b0, 1'b0, 1'b0, r, lat);
    chk("w32_l1_carry", act_res[3], 515'(33'h1_0000_0000));
    chk("w32_l8_carry", act_res[1], 515'(33'h1_0000_0000));
    run_op(514'd0, 514'd1, 1'b1, 1'b0, 1'b0, r, lat);
    chk("sub_zero_minus_one", r, '1);
    chk("w32_l1_borrow", act_res[3], 515'(33'h1_FFFF_FFFF));

    for (int i = 0; i < 20; i++) begin
      run_op(rnd514(), rnd514(), 1'($urandom), 1'($urandom), 1'(i % 3 == 0), r, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mpadder.md
# mpadder

Parametrised multi-cycle wide adder/subtractor for the Montgomery datapath. It is the successor to the single-cycle 514-bit adder. It processes operands LIMB bits per clock with a registered carry, which breaks the long carry chain for timing closure. It supports add, subtract and an optional final right-shift by one, and uses a start/done handshake to the Montgomery controller.

## Interface
Parameters:
- WIDTH, 514: operand width in bits; the result is WIDTH+1 bits.
- LIMB, 128: bits processed per cycle; 1 ≤ LIMB ≤ WIDTH+1.
- NLIMBS (local), ceil((WIDTH+1)/LIMB): number of processing cycles.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- resetn  in  1  reset, synchronous and active-low.
- start  in  1  request a new operation; sampled only when the block can accept.
- subtract  in  1  0: a+b; 1: a−b. Captured with start.
- shift  in  1  1: result shifted right by one bit (logical). Captured with start.
- in_a  in  WIDTH  operand A, unsigned. Captured on the accepting edge.
- in_b  in  WIDTH  operand B, unsigned. Captured on the accepting edge.
- result  out  WIDTH+1  registered result; valid while done=1 and held until the next accept.
- done  out  1  single-cycle pulse; result valid.
- busy  out  1  high while an operation is in flight (state ADD).

## Operation
- States: IDLE, ADD, DONE.
- Accept condition: start=1 while in IDLE or DONE. On the accepting edge:
  - in_a, in_b, subtract and shift are latched. Operands are zero-extended to NLIMBS·LIMB bits.
  - If subtract=1, B is stored inverted over the full extended width and the carry register is set to 1. Otherwise the carry register is set to 0.
  - The limb counter is set to 0 and the state moves to ADD.
- ADD: each cycle adds limb i of A, limb i of (possibly inverted) B and the carry.
  - The LIMB-bit sum goes into the accumulator. The carry-out goes into the carry register. The counter increments.
  - On the cycle with counter=NLIMBS−1, the final value is written to result and the state moves to DONE.
- Final value: S = low WIDTH+1 bits of the accumulated sum.
  - Add: S = a+b. Full precision, no overflow is possible.
  - Subtract: S = (a−b) mod 2^(WIDTH+1). Bit WIDTH is set iff a<b, so it serves as the borrow/sign bit.
  - shift=1: result = S>>1 (logical; result[WIDTH]=0). Otherwise result = S.
- DONE: done=1 for exactly this one cycle.
  - With start=1: accept a new operation (back-to-back) and go to ADD.
  - Otherwise: go to IDLE.
- start in ADD is ignored. No queueing; the controller must wait for done.
- Inputs change freely outside the accepting edge. Only latched values are used.

## Timing
- Reset values (resetn=0 at an edge): state IDLE, result=0, done=0, busy=0, carry=0, counter=0.
  - Reset applied mid-operation aborts the operation. No done is produced.
- Latency: the accept at edge E0 yields done=1 and a valid result in the cycle following edge E0+NLIMBS.
  - Default: NLIMBS=5, so done rises 5 edges after accept.
- busy=1 in the cycles after E0 through E0+NLIMBS−1. busy=0 while done=1.
- Throughput: one operation per NLIMBS+1 cycles with back-to-back start held high.
- result changes only on the final ADD edge or on reset. It is stable through DONE and IDLE.
- Degenerate case LIMB ≥ WIDTH+1: NLIMBS=1, and done follows the accept by one edge.

## Test plan
- Reset mid-op: start, then resetn=0 at edge E0+2 → no done pulse; result=0 and busy=0 after reset; the next start completes normally.
- Add with full carry propagation: a=2^514−1, b=1, subtract=0, shift=0 → result=2^514 (bit 514 set, others 0); done exactly 5 edges after accept.
- Subtract with borrow: a=5, b=7, subtract=1 → result=2^515−2 (bit 514=1). Also a=7, b=5 → result=2, bit 514=0.
- Shift: a=2^514−1, b=2^514−1, add, shift=1 → result=2^514−1. Also a=3, b=0, shift=1 → result=1.
- Back-to-back and ignored start:
  - Hold start=1 across two ops (1+2, then 10−4) → done pulses 6 cycles apart with results 3 and 6.
  - Pulse start during ADD → no effect.
- Parameter sweep: WIDTH=32 with LIMB=8, 33 and 1 → NLIMBS=5, 1 and 33 respectively. Random add/sub/shift vectors must match the reference model.
